// File: rtl/vgachargen_pkg.sv
// Shared definitions for the character-generator display path.
// Holds the default 640x480@60 raster timing, widths derived from it and
// the run-control state encoding used by vga_timing_gen.
package vgachargen_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_HTOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_VTOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_HW     = $clog2(VGA_HTOTAL);
    localparam int VGA_VW     = $clog2(VGA_VTOTAL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register with a programmable reset value.
// Ports: clk_i/arstn_i clock and async active-low reset, en_i shift enable,
//        d_i input word, q_o word delayed by DEPTH enabled clocks.
// DEPTH=0 degenerates to a wire.
module vga_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                pipe_q <= {DEPTH{RST_VAL}};
            end else if (en_i) begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign q_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator for the character-generator path.
// Ports: clk_i, arstn_i (async active-low), pix_en_i pixel strobe, en_i run
//        request; hcount_o/vcount_o raster position, de_o undelayed display
//        enable, cell_x/y_o + bit_x/y_o glyph coordinates, cell_addr_o linear
//        character-map address, line_start_o/frame_start_o pulses,
//        hsync_o/vsync_o/de_dly_o delayed by SYNC_DELAY consumed pixels.
module vga_timing_gen
    import vgachargen_pkg::*;
#(
    parameter int H_DISPLAY        = VGA_H_DISPLAY,
    parameter int H_FRONT          = VGA_H_FRONT,
    parameter int H_SYNC           = VGA_H_SYNC,
    parameter int H_BACK           = VGA_H_BACK,
    parameter int V_DISPLAY        = VGA_V_DISPLAY,
    parameter int V_FRONT          = VGA_V_FRONT,
    parameter int V_SYNC           = VGA_V_SYNC,
    parameter int V_BACK           = VGA_V_BACK,
    parameter bit HSYNC_ACTIVE_LOW = 1'b1,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int CELL_W           = 8,
    parameter int CELL_H           = 16,
    parameter int SYNC_DELAY       = 2,
    localparam int HTOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int VTOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int HW     = $clog2(HTOTAL),
    localparam int VW     = $clog2(VTOTAL),
    localparam int CX     = H_DISPLAY / CELL_W,
    localparam int CY     = V_DISPLAY / CELL_H,
    localparam int AW     = $clog2(CX * CY),
    localparam int CXW    = $clog2(CX),
    localparam int CYW    = $clog2(CY),
    localparam int BXW    = $clog2(CELL_W),
    localparam int BYW    = $clog2(CELL_H)
) (
    input  logic           clk_i,
    input  logic           arstn_i,
    input  logic           pix_en_i,
    input  logic           en_i,
    output logic [HW-1:0]  hcount_o,
    output logic [VW-1:0]  vcount_o,
    output logic           de_o,
    output logic [CXW-1:0] cell_x_o,
    output logic [CYW-1:0] cell_y_o,
    output logic [BXW-1:0] bit_x_o,
    output logic [BYW-1:0] bit_y_o,
    output logic [AW-1:0]  cell_addr_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_dly_o
);

    if ((CELL_W & (CELL_W - 1)) != 0 || (H_DISPLAY % CELL_W) != 0) begin : g_bad_cell_w
        $error("CELL_W must be a power of two dividing H_DISPLAY");
    end
    if ((CELL_H & (CELL_H - 1)) != 0 || (V_DISPLAY % CELL_H) != 0) begin : g_bad_cell_h
        $error("CELL_H must be a power of two dividing V_DISPLAY");
    end

    localparam logic [HW-1:0]  H_LAST   = HW'(HTOTAL - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(VTOTAL - 1);
    localparam logic [HW-1:0]  H_DISP   = HW'(H_DISPLAY);
    localparam logic [VW-1:0]  V_DISP   = VW'(V_DISPLAY);
    localparam logic [HW-1:0]  HS_START = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0]  HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VW-1:0]  VS_START = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0]  VS_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [BYW-1:0] BY_LAST  = BYW'(CELL_H - 1);
    localparam logic [AW-1:0]  ROW_STEP = AW'(CX);

    vga_state_e     state_q, state_d;
    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic [AW-1:0]  row_q, row_d;

    logic active, h_last, v_last, frame_wrap, de;
    logic hs_raw, vs_raw;

    assign active     = (state_q != ST_IDLE);
    assign h_last     = (h_q == H_LAST);
    assign v_last     = (v_q == V_LAST);
    assign frame_wrap = active & pix_en_i & h_last & v_last;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en_i) state_d = ST_RUN;
            ST_RUN:   if (!en_i) state_d = ST_DRAIN;
            // Dropping en_i only stops at the frame boundary, never mid-frame.
            ST_DRAIN: if (en_i) state_d = ST_RUN;
                      else if (frame_wrap) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters and the row-base register. The row base tracks cell_y*CX by
    // adding CX whenever the last scanline of a glyph row finishes.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        row_d = row_q;
        if (!active) begin
            h_d   = '0;
            v_d   = '0;
            row_d = '0;
        end else if (pix_en_i) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
            if (frame_wrap)
                row_d = '0;
            else if (h_last && v_q < V_DISP && v_q[BYW-1:0] == BY_LAST)
                row_d = row_q + ROW_STEP;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            row_q   <= row_d;
        end
    end

    assign de = active & (h_q < H_DISP) & (v_q < V_DISP);

    assign hcount_o      = h_q;
    assign vcount_o      = v_q;
    assign de_o          = de;
    assign bit_x_o       = de ? h_q[BXW-1:0]    : '0;
    assign bit_y_o       = de ? v_q[BYW-1:0]    : '0;
    assign cell_x_o      = de ? h_q[BXW +: CXW] : '0;
    assign cell_y_o      = de ? v_q[BYW +: CYW] : '0;
    assign cell_addr_o   = de ? row_q + AW'(cell_x_o) : '0;
    assign line_start_o  = active & pix_en_i & (h_q == '0);
    assign frame_start_o = line_start_o & (v_q == '0);

    // Gated by active so IDLE feeds inactive levels into the delay line.
    assign hs_raw = active & (h_q >= HS_START) & (h_q < HS_END);
    assign vs_raw = active & (v_q >= VS_START) & (v_q < VS_END);

    vga_sync_delay #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL ({HSYNC_ACTIVE_LOW, VSYNC_ACTIVE_LOW, 1'b0})
    ) u_sync_delay (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .en_i    (pix_en_i),
        .d_i     ({hs_raw ^ HSYNC_ACTIVE_LOW, vs_raw ^ VSYNC_ACTIVE_LOW, de}),
        .q_o     ({hsync_o, vsync_o, de_dly_o})
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunk raster (24x38 total, 16x32 visible,
// 4x8 glyph cells) so full frames fit in a short run.
module tb_vga_timing_gen;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 32, VF = 2, VS = 2, VB = 2;
    localparam int CW = 4, CH = 8, SD = 2;
    localparam int HT = HD + HF + HS + HB;   // 24
    localparam int VT = VD + VF + VS + VB;   // 38
    localparam int CX = HD / CW;             // 4

    logic       clk_i = 1'b0;
    logic       arstn_i, pix_en_i, en_i;
    logic [4:0] hcount_o;
    logic [5:0] vcount_o;
    logic       de_o;
    logic [1:0] cell_x_o, cell_y_o, bit_x_o;
    logic [2:0] bit_y_o;
    logic [3:0] cell_addr_o;
    logic       line_start_o, frame_start_o, hsync_o, vsync_o, de_dly_o;

    always #5 clk_i = ~clk_i;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_ACTIVE_LOW(1'b1), .VSYNC_ACTIVE_LOW(1'b1),
        .CELL_W(CW), .CELL_H(CH), .SYNC_DELAY(SD)
    ) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .pix_en_i(pix_en_i), .en_i(en_i),
        .hcount_o(hcount_o), .vcount_o(vcount_o), .de_o(de_o),
        .cell_x_o(cell_x_o), .cell_y_o(cell_y_o),
        .bit_x_o(bit_x_o), .bit_y_o(bit_y_o), .cell_addr_o(cell_addr_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_dly_o(de_dly_o)
    );

    typedef struct {
        int h, v, de, cx, cy, bx, by, addr, ls, fs, hs, vs, dd;
    } exp_t;

    typedef struct {
        int h, v, addr, cx, cy, bx, by;
    } cell_vec_t;

    exp_t sb_q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0;
    int   last_fs_cyc = -1, prev_fs_cyc = -1;

    // Reference model: state 0 idle, 1 run, 2 drain.
    int m_st, m_h, m_v;
    bit d1_hs, d1_vs, d1_de, d2_hs, d2_vs, d2_de;

    // Values sampled at the last step.
    int s_h, s_v;
    bit s_fs, s_hs, s_vs, s_dd, s_pe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_h = 0; m_v = 0;
        d1_hs = 0; d1_vs = 0; d1_de = 0;
        d2_hs = 0; d2_vs = 0; d2_de = 0;
    endtask

    function automatic exp_t model_exp(input bit pe);
        exp_t e;
        bit act, de;
        act    = (m_st != 0);
        de     = act && m_h < HD && m_v < VD;
        e.h    = m_h;
        e.v    = m_v;
        e.de   = de;
        e.cx   = de ? m_h / CW : 0;
        e.cy   = de ? m_v / CH : 0;
        e.bx   = de ? m_h % CW : 0;
        e.by   = de ? m_v % CH : 0;
        e.addr = de ? (m_v / CH) * CX + m_h / CW : 0;
        e.ls   = (act && m_h == 0 && pe) ? 1 : 0;
        e.fs   = (e.ls == 1 && m_v == 0) ? 1 : 0;
        e.hs   = d2_hs ? 0 : 1;
        e.vs   = d2_vs ? 0 : 1;
        e.dd   = d2_de;
        return e;
    endfunction

    task automatic model_clk(input bit pe, input bit en);
        bit rh, rv, rd, act;
        int nst;
        act = (m_st != 0);
        rh  = act && m_h >= HD + HF && m_h < HD + HF + HS;
        rv  = act && m_v >= VD + VF && m_v < VD + VF + VS;
        rd  = act && m_h < HD && m_v < VD;
        nst = m_st;
        case (m_st)
            0: if (en) nst = 1;
            1: if (!en) nst = 2;
            default: if (en) nst = 1;
                     else if (pe && m_h == HT - 1 && m_v == VT - 1) nst = 0;
        endcase
        if (act && pe) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
        end
        if (pe) begin
            d2_hs = d1_hs; d2_vs = d1_vs; d2_de = d1_de;
            d1_hs = rh;    d1_vs = rv;    d1_de = rd;
        end
        m_st = nst;
    endtask

    // Called at posedge+1: drive, settle, score, then advance one clock.
    task automatic step(input bit pe, input bit en);
        exp_t e;
        pix_en_i = pe;
        en_i     = en;
        #1;
        sb_q.push_back(model_exp(pe));
        e = sb_q.pop_front();
        check("hcount",      hcount_o,      e.h);
        check("vcount",      vcount_o,      e.v);
        check("de",          de_o,          e.de);
        check("cell_x",      cell_x_o,      e.cx);
        check("cell_y",      cell_y_o,      e.cy);
        check("bit_x",       bit_x_o,       e.bx);
        check("bit_y",       bit_y_o,       e.by);
        check("cell_addr",   cell_addr_o,   e.addr);
        check("line_start",  line_start_o,  e.ls);
        check("frame_start", frame_start_o, e.fs);
        check("hsync",       hsync_o,       e.hs);
        check("vsync",       vsync_o,       e.vs);
        check("de_dly",      de_dly_o,      e.dd);
        s_h = hcount_o; s_v = vcount_o; s_fs = frame_start_o;
        s_hs = hsync_o; s_vs = vsync_o; s_dd = de_dly_o; s_pe = pe;
        if (frame_start_o) begin
            prev_fs_cyc = last_fs_cyc;
            last_fs_cyc = cyc;
        end
        @(posedge clk_i);
        cyc++;
        model_clk(pe, en);
        #1;
    endtask

    task automatic run_to(input int h, input int v, input bit en);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < 2000) begin
            step(1'b1, en);
            n++;
        end
        check("run_to_h", hcount_o, h);
        check("run_to_v", vcount_o, v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cell_vec_t tbl[7];
        bit got;
        int t0, hs_falls, vs_falls, hs_low, vs_low;
        bit p_hs, p_vs, p_dd;

        tbl = '{'{4, 8, 5, 1, 1, 0, 0},
                '{5, 9, 5, 1, 1, 1, 1},
                '{10, 20, 10, 2, 2, 2, 4},
                '{15, 31, 15, 3, 3, 3, 7},
                '{16, 31, 0, 0, 0, 0, 0},
                '{0, 32, 0, 0, 0, 0, 0},
                '{3, 0, 0, 0, 0, 3, 0}};

        // Reset state
        arstn_i = 1'b0; pix_en_i = 1'b0; en_i = 1'b0;
        model_reset();
        #12;
        check("rst_hcount",   hcount_o,      0);
        check("rst_vcount",   vcount_o,      0);
        check("rst_de",       de_o,          0);
        check("rst_de_dly",   de_dly_o,      0);
        check("rst_hsync",    hsync_o,       1);
        check("rst_vsync",    vsync_o,       1);
        check("rst_ls",       line_start_o,  0);
        check("rst_fs",       frame_start_o, 0);
        check("rst_addr",     cell_addr_o,   0);
        @(posedge clk_i); #1;
        arstn_i = 1'b1;

        // Full frame with pix_en every 4th clock
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step(cyc % 4 == 0, 1'b1);
            got = s_fs;
        end
        check("first_frame_start", got, 1);
        t0 = last_fs_cyc;
        hs_falls = 0; vs_falls = 0; hs_low = 0; vs_low = 0;
        p_hs = s_hs; p_vs = s_vs; p_dd = s_dd;
        for (int i = 0; i < 5000; i++) begin
            step(cyc % 4 == 0, 1'b1);
            if (s_fs) break;
            if (p_hs && !s_hs) begin
                hs_falls++;
                check("hsync_fall_h", s_h, HD + HF + SD);
            end
            if (p_vs && !s_vs) begin
                vs_falls++;
                check("vsync_fall_v", s_v, VD + VF);
                check("vsync_fall_h", s_h, SD);
            end
            if (p_dd && !s_dd) check("de_dly_fall_h", s_h, HD + SD);
            if (s_pe && !s_hs) hs_low++;
            if (s_pe && !s_vs) vs_low++;
            p_hs = s_hs; p_vs = s_vs; p_dd = s_dd;
        end
        check("frame_period_clks", last_fs_cyc - t0, HT * VT * 4);
        check("hsync_pulses",      hs_falls, VT);
        check("hsync_low_pixels",  hs_low,   VT * HS);
        check("vsync_pulses",      vs_falls, 1);
        check("vsync_low_pixels",  vs_low,   VS * HT);

        // Cell coordinate / address table
        foreach (tbl[i]) begin
            run_to(tbl[i].h, tbl[i].v, 1'b1);
            check("tbl_addr",   cell_addr_o, tbl[i].addr);
            check("tbl_cell_x", cell_x_o,    tbl[i].cx);
            check("tbl_cell_y", cell_y_o,    tbl[i].cy);
            check("tbl_bit_x",  bit_x_o,     tbl[i].bx);
            check("tbl_bit_y",  bit_y_o,     tbl[i].by);
        end

        // Stop request at line 10: remainder of the frame, then idle
        run_to(0, 10, 1'b1);
        for (int i = 0; i < (VT - 10) * HT; i++) step(1'b1, 1'b0);
        check("stop_hcount", hcount_o, 0);
        check("stop_vcount", vcount_o, 0);
        check("stop_de",     de_o,     0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("idle_hcount_held", hcount_o, 0);

        // Restart, drop en_i, re-raise in DRAIN: no gap in frames
        step(1'b1, 1'b1);
        run_to(0, 10, 1'b1);
        run_to(0, 20, 1'b0);
        run_to(0, 0, 1'b1);
        step(1'b1, 1'b1);
        check("rearm_fs",        s_fs, 1);
        check("rearm_fs_period", last_fs_cyc - prev_fs_cyc, HT * VT);

        // Asynchronous reset mid-line
        run_to(10, 5, 1'b1);
        check("pre_rst_de", de_o, 1);
        pix_en_i = 1'b0;
        arstn_i  = 1'b0;
        #1;
        check("arst_de",     de_o,     0);
        check("arst_hsync",  hsync_o,  1);
        check("arst_vsync",  vsync_o,  1);
        check("arst_hcount", hcount_o, 0);
        check("arst_de_dly", de_dly_o, 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("post_rst_fs", s_fs, 1);
        check("post_rst_h",  s_h,  0);
        run_to(5, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the character-generator display path. Produces pixel counters, data-enable, programmable-polarity H/V sync, per-pixel character-cell coordinates and a multiplier-free linear character-map address. The sync/DE outputs are delayed to line up with a downstream glyph-fetch pipeline. It sits between the pixel-clock enable source and the char/colour map lookup stage, and supports graceful end-of-frame stop.

## Interface
- H_DISPLAY, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal timing in pixels
- V_DISPLAY, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical timing in lines
- HSYNC_ACTIVE_LOW, 1; VSYNC_ACTIVE_LOW, 1: sync polarity (1 = pulse low)
- CELL_W, 8; CELL_H, 16: glyph cell size in pixels; power of two; must divide H_DISPLAY / V_DISPLAY (elaboration-time error otherwise)
- SYNC_DELAY, 2: pixel stages of delay on hsync_o/vsync_o/de_dly_o (0 = no delay)
- Derived: HW=$clog2(HTOTAL), VW=$clog2(VTOTAL), CX=H_DISPLAY/CELL_W, CY=V_DISPLAY/CELL_H, AW=$clog2(CX*CY)
- clk_i  in  1  system clock
- arstn_i  in  1  asynchronous active-low reset
- pix_en_i  in  1  pixel strobe; one pixel is consumed per clock where high
- en_i  in  1  run request
- hcount_o  out  HW  current pixel column
- vcount_o  out  VW  current line
- de_o  out  1  current pixel is in the display area (undelayed)
- cell_x_o  out  $clog2(CX)  glyph column; cell_y_o  out  $clog2(CY)  glyph row
- bit_x_o  out  $clog2(CELL_W)  pixel within glyph; bit_y_o  out  $clog2(CELL_H)  line within glyph
- cell_addr_o  out  AW  cell_y*CX + cell_x
- line_start_o  out  1  pulse; frame_start_o  out  1  pulse
- hsync_o, vsync_o, de_dly_o  out  1 each  delayed sync/DE

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: h=v=0 held. de_o=0, pulses=0, cell/bit/addr outputs=0. Syncs are fed inactive into the delay chain. en_i=1 → RUN.
- RUN: on pix_en_i, h increments; at h=HTOTAL-1, h→0 and v increments; at v=VTOTAL-1 with h wrap, v→0. en_i=0 → DRAIN.
- DRAIN: counts as RUN. en_i=1 → RUN with no gap. Wrap from (HTOTAL-1, VTOTAL-1) on pix_en_i → IDLE, so no truncated frames.
- de_o = RUN/DRAIN & h<H_DISPLAY & v<V_DISPLAY.
- Raw hsync is active for H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC. Raw vsync is active for the same window on v, independent of h. Output level = active ? !ACTIVE_LOW : ACTIVE_LOW.
- bit_x/bit_y = low bits of h/v; cell_x/cell_y = upper bits. All four are forced to 0 when de_o=0.
- cell_addr_o is built from a row-base register with no multiplier:
  - row base +CX when a line inside the display area ends with bit_y=CELL_H-1;
  - row base clears at frame wrap.
  - cell_addr_o = row base + cell_x when de_o=1, else 0.
- line_start_o = RUN/DRAIN & h==0 & pix_en_i. frame_start_o = line_start_o & v==0.
- Delay chain: SYNC_DELAY registers of {hsync, vsync, de}, shifting only on pix_en_i.

## Timing
- Counters and state are registered. de_o, the cell outputs and the pulses are combinational from the registers, so they describe the current pixel.
- Start latency: en_i seen high at edge k → pixel (0,0) is presented from edge k until the first pix_en_i edge in RUN.
- pix_en_i low stalls everything, pulses included; pulses are never repeated during a stall.
- hsync_o/vsync_o/de_dly_o lag the raw values by exactly SYNC_DELAY consumed pixels.
- Reset values: counters 0; de_o, de_dly_o and pulses 0; hsync_o/vsync_o at inactive level; row base 0.
- arstn_i assertion mid-frame takes effect immediately, without a clock edge.

## Structure
- Shared package vgachargen_pkg holds:
  - default 640x480 timing constants;
  - derived widths;
  - the state enum typedef (IDLE/RUN/DRAIN).
- Sub-module vga_sync_delay: parametrised width/depth shift register with enable and reset value, used for the {hsync, vsync, de} chain.

## Test plan
- Defaults, pix_en_i every 4th clock → 525 hsync-low pulses per frame, each 96 pixels starting at h=656; vsync low on lines 490–491; frame_start_o period 1,680,000 clocks.
- Cell address check → at (h=8, v=16): cell_addr_o=81, cell_x=1, cell_y=1, bit_x=0, bit_y=0. At (639, 479): cell_addr_o=2399, cell_x=79, cell_y=29, bit_x=7, bit_y=15. At h=640: all four cell/bit outputs and cell_addr_o are 0.
- Stop request:
  - en_i dropped at v=100 → frame completes to (799, 524), then IDLE with hcount_o=0 and de_o=0.
  - en_i re-raised in DRAIN at v=300 → next frame_start_o exactly one frame period later.
- SYNC_DELAY=2 → hsync_o falls 2 pixels after h=656; de_dly_o falls 2 pixels after h=640.
- arstn_i low at h=300 mid-line → syncs inactive and de_o=0 with no clock edge. After release with en_i=1: counting resumes from (0,0), frame_start_o on the first pixel.
- HSYNC_ACTIVE_LOW=0, VSYNC_ACTIVE_LOW=0 → syncs idle at 0 and pulse high; counts identical to the first scenario.
